// File: rtl/core_mem_responder.sv
// rtl/core_mem_responder.sv - round-robin multi-core load/store responder for a shared synchronous BRAM
module core_mem_responder #(
    parameter int NUM_CORES        = 2,
    parameter int DATA_WIDTH       = 32,
    parameter int ADDRESS_BITS     = 32,
    parameter int MEM_ADDRESS_BITS = 14
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_CORES-1:0]               req_valid,
    input  logic [NUM_CORES-1:0]               req_write,
    input  logic [NUM_CORES*ADDRESS_BITS-1:0]  req_address,
    input  logic [NUM_CORES*DATA_WIDTH-1:0]    req_wdata,
    output logic [NUM_CORES-1:0]               req_ready,
    output logic [NUM_CORES-1:0]               resp_valid,
    output logic [NUM_CORES-1:0]               resp_error,
    output logic [DATA_WIDTH-1:0]              resp_rdata,
    output logic                               bram_en,
    output logic                               bram_we,
    output logic [MEM_ADDRESS_BITS-1:0]        bram_addr,
    output logic [DATA_WIDTH-1:0]              bram_wdata,
    input  logic [DATA_WIDTH-1:0]              bram_rdata,
    output logic                               busy
);

    localparam int ID_BITS = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int HI_BITS = ADDRESS_BITS - MEM_ADDRESS_BITS - 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    state_t                      state;
    state_t                      state_next;

    logic [ID_BITS-1:0]          last_grant;
    logic [ID_BITS-1:0]          owner;
    logic [ID_BITS-1:0]          grant_id;
    logic                        grant_found;
    logic                        accept;

    logic [MEM_ADDRESS_BITS-1:0] sel_word;
    logic [HI_BITS-1:0]          sel_hi;
    logic [DATA_WIDTH-1:0]       sel_wdata;
    logic                        sel_write;
    logic                        sel_oor;

    logic                        err_q;
    logic                        load_q;
    logic [DATA_WIDTH-1:0]       rdata_q;
    logic                        unused_offset_bits;

    // Round-robin pick: lowest requesting core above last_grant, else lowest at or below it
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req_valid[i] && (ID_BITS'(i) <= last_grant)) begin
                grant_found = 1'b1;
                grant_id    = ID_BITS'(i);
            end
        end
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (req_valid[i] && (ID_BITS'(i) > last_grant)) begin
                grant_found = 1'b1;
                grant_id    = ID_BITS'(i);
            end
        end
    end

    // Payload of the granted core; byte offset bits are deliberately dropped
    always_comb begin
        sel_word  = req_address[int'(grant_id) * ADDRESS_BITS + 2 +: MEM_ADDRESS_BITS];
        sel_hi    = req_address[int'(grant_id) * ADDRESS_BITS + MEM_ADDRESS_BITS + 2 +: HI_BITS];
        sel_wdata = req_wdata[int'(grant_id) * DATA_WIDTH +: DATA_WIDTH];
        sel_write = req_write[grant_id];
        sel_oor   = |sel_hi;
        accept    = (state == IDLE) && grant_found;
    end

    // Byte offsets carry no meaning for word-wide BRAM accesses
    always_comb begin
        unused_offset_bits = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            unused_offset_bits = unused_offset_bits ^ (^req_address[i * ADDRESS_BITS +: 2]);
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: loads take the extra read cycle, stores and errors go straight to RESP
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (sel_oor || sel_write) ? RESP : RD_WAIT;
                end
            end
            RD_WAIT: state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Transaction context captured at acceptance, read data captured in RD_WAIT
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant <= ID_BITS'(NUM_CORES - 1);
            owner      <= '0;
            err_q      <= 1'b0;
            load_q     <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (accept) begin
                last_grant <= grant_id;
                owner      <= grant_id;
                err_q      <= sel_oor;
                load_q     <= !sel_write;
            end
            if (state == RD_WAIT) begin
                rdata_q <= bram_rdata;
            end
        end
    end

    // Strobes and data outputs; held at zero while reset is asserted, even with requests pending
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        resp_error = '0;
        resp_rdata = '0;
        bram_en    = 1'b0;
        bram_we    = 1'b0;
        bram_addr  = '0;
        bram_wdata = '0;
        if (reset) begin
            if (accept) begin
                req_ready[grant_id] = 1'b1;
                if (!sel_oor) begin
                    bram_en   = 1'b1;
                    bram_we   = sel_write;
                    bram_addr = sel_word;
                    if (sel_write) begin
                        bram_wdata = sel_wdata;
                    end
                end
            end
            if (state == RESP) begin
                resp_valid[owner] = 1'b1;
                resp_error[owner] = err_q;
                if (load_q && !err_q) begin
                    resp_rdata = rdata_q;
                end
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_core_mem_responder.sv
// tb/tb_core_mem_responder.sv - directed self-checking bench for core_mem_responder
module tb_core_mem_responder;

    localparam int NC = 2;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MW = 14;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [NC-1:0]     req_valid = '0;
    logic [NC-1:0]     req_write = '0;
    logic [NC*AW-1:0]  req_address = '0;
    logic [NC*DW-1:0]  req_wdata = '0;
    logic [NC-1:0]     req_ready;
    logic [NC-1:0]     resp_valid;
    logic [NC-1:0]     resp_error;
    logic [DW-1:0]     resp_rdata;
    logic              bram_en;
    logic              bram_we;
    logic [MW-1:0]     bram_addr;
    logic [DW-1:0]     bram_wdata;
    logic [DW-1:0]     bram_rdata;
    logic              busy;

    logic [DW-1:0]     mem [0:(1<<MW)-1];

    int n_checks = 0;
    int n_errors = 0;

    core_mem_responder #(
        .NUM_CORES(NC), .DATA_WIDTH(DW), .ADDRESS_BITS(AW), .MEM_ADDRESS_BITS(MW)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid),
        .resp_error(resp_error), .resp_rdata(resp_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_wdata(bram_wdata), .bram_rdata(bram_rdata), .busy(busy)
    );

    always #5 clock = ~clock;

    // Synchronous BRAM model: one-cycle read latency
    always @(posedge clock) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_wdata;
            else         bram_rdata <= mem[bram_addr];
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request at a negedge, follow it to its response and back to IDLE
    task automatic transact(input string tag, input int core, input bit wr,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int exp_lat, input bit exp_err, input logic [31:0] exp_rdata);
        int lat;
        req_valid[core]               = 1'b1;
        req_write[core]               = wr;
        req_address[core*AW +: AW]    = addr;
        req_wdata[core*DW +: DW]      = wdata;
        #1;
        check_val({tag, "_ready"}, 32'(req_ready), 32'(1 << core));
        check_val({tag, "_bram_en"}, 32'(bram_en), 32'(!exp_err));
        if (!exp_err) begin
            check_val({tag, "_bram_addr"}, 32'(bram_addr), 32'(addr[MW+1:2]));
            check_val({tag, "_bram_we"}, 32'(bram_we), 32'(wr));
        end
        @(posedge clock);
        @(negedge clock);
        req_valid[core] = 1'b0;
        lat = 1;
        while (lat <= 5 && !resp_valid[core]) begin
            @(negedge clock);
            lat++;
        end
        check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check_val({tag, "_resp_valid"}, 32'(resp_valid), 32'(1 << core));
        check_val({tag, "_resp_error"}, 32'(resp_error), exp_err ? 32'(1 << core) : 32'd0);
        check_val({tag, "_resp_rdata"}, resp_rdata, exp_rdata);
        @(negedge clock);
        check_val({tag, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [1:0] grants [0:7];
        logic [1:0] resps  [0:7];
        int ng;
        int nresp;
        int cnt;

        mem[0]  <= 32'h0BAD_F00D;
        mem[5]  <= 32'd2000;
        mem[10] <= 32'd1000;

        // Reset state
        @(negedge clock);
        #1;
        check_val("rst_req_ready", 32'(req_ready), 32'd0);
        check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_val("rst_resp_error", 32'(resp_error), 32'd0);
        check_val("rst_resp_rdata", resp_rdata, 32'd0);
        check_val("rst_bram_en", 32'(bram_en), 32'd0);
        check_val("rst_bram_we", 32'(bram_we), 32'd0);
        check_val("rst_bram_addr", 32'(bram_addr), 32'd0);
        check_val("rst_bram_wdata", bram_wdata, 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Both cores load 0x14 continuously from reset: grants alternate starting with core 0
        req_write   = '0;
        req_address = {32'h14, 32'h14};
        req_valid   = 2'b11;
        ng = 0;
        nresp = 0;
        for (int c = 0; c < 40 && nresp < 4; c++) begin
            #1;
            if (req_ready != 0) begin
                if (ng < 8) grants[ng] = req_ready;
                ng++;
            end
            if (resp_valid != 0) begin
                if (nresp < 8) resps[nresp] = resp_valid;
                check_val("rr_rdata", resp_rdata, 32'd2000);
                nresp++;
            end
            if (nresp < 4) @(negedge clock);
        end
        req_valid = '0;
        check_val("rr_num_grants", 32'(ng), 32'd4);
        check_val("rr_num_resps", 32'(nresp), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check_val("rr_grant_order", 32'(grants[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
            check_val("rr_resp_order", 32'(resps[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        @(negedge clock);
        check_val("rr_idle", 32'(busy), 32'd0);

        // Single load of word 10
        transact("load0", 0, 1'b0, 32'h28, 32'h0, 2, 1'b0, 32'd1000);

        // Store then load through core 1
        transact("store1", 1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1, 1'b0, 32'd0);
        check_val("store1_mem", mem[64], 32'hDEAD_BEEF);
        transact("load1", 1, 1'b0, 32'h100, 32'h0, 2, 1'b0, 32'hDEAD_BEEF);

        // Out-of-range load and store
        transact("oor_load", 0, 1'b0, 32'h0001_0000, 32'h0, 1, 1'b1, 32'd0);
        transact("oor_store", 0, 1'b1, 32'h0001_0000, 32'h1234_5678, 1, 1'b1, 32'd0);
        check_val("oor_store_mem", mem[0], 32'h0BAD_F00D);

        // Idle for 20 cycles
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (bram_en || busy || req_ready != 0) cnt++;
        end
        check_val("idle_activity", 32'(cnt), 32'd0);

        // Unaligned load: offset bits ignored
        transact("unaligned", 0, 1'b0, 32'h2B, 32'h0, 2, 1'b0, 32'd1000);

        // Reset in RD_WAIT
        req_valid[0]        = 1'b1;
        req_write[0]        = 1'b0;
        req_address[0 +: AW] = 32'h28;
        @(posedge clock);
        @(negedge clock);
        req_valid[0] = 1'b0;
        #1;
        check_val("mid_busy_before", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        req_valid[1]          = 1'b1;
        req_address[AW +: AW] = 32'h28;
        #1;
        check_val("mid_busy", 32'(busy), 32'd0);
        check_val("mid_req_ready", 32'(req_ready), 32'd0);
        check_val("mid_bram_en", 32'(bram_en), 32'd0);
        check_val("mid_resp_valid", 32'(resp_valid), 32'd0);
        check_val("mid_resp_rdata", resp_rdata, 32'd0);
        @(negedge clock);
        @(negedge clock);
        req_valid = '0;
        reset = 1'b1;
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            if (resp_valid != 0 || busy) cnt++;
        end
        check_val("mid_no_resp_after", 32'(cnt), 32'd0);
        transact("post_rst", 0, 1'b0, 32'h28, 32'h0, 2, 1'b0, 32'd1000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
